row_writer: RTL and testbench

// - Write-side counterpart of the ROM row bus: accepts a full parallel image row
//   (im_size pixels), serialises it into single-pixel RAM writes with an

---
 rtl/bus_pkg.sv | 15 +
 rtl/row_writer_if.sv | 34 +++
 rtl/row_serializer.sv | 43 ++++
 rtl/row_writer.sv | 136 +++++++++++++
 tb/tb_row_writer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared row-bus definitions: default image geometry and the row_writer state encoding.
// The ROM-read side of the row bus uses the same package.
package bus_pkg;

    localparam int BIT_WIDTH_DEF  = 16;
    localparam int IM_SIZE_DEF    = 28;
    localparam int FRAME_ROWS_DEF = 28;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } rw_state_t;

endpackage

// File: rtl/row_writer_if.sv
// Row-in handshake plus single-pixel RAM write port of the feature-map writer.
// The slave side is the row_writer itself; the master side is the producer/RAM environment.
interface row_writer_if #(
    parameter int bitWidth   = bus_pkg::BIT_WIDTH_DEF,
    parameter int im_size    = bus_pkg::IM_SIZE_DEF,
    parameter int addr_width = 11
);

    logic                        row_valid;
    logic                        row_ready;
    logic [bitWidth*im_size-1:0] row_in;
    logic                        ram_we;
    logic [addr_width-1:0]       ram_addr;
    logic [bitWidth-1:0]         ram_data;

    modport master (
        output row_valid,
        output row_in,
        input  row_ready,
        input  ram_we,
        input  ram_addr,
        input  ram_data
    );

    modport slave (
        input  row_valid,
        input  row_in,
        output row_ready,
        output ram_we,
        output ram_addr,
        output ram_data
    );

endinterface

// File: rtl/row_serializer.sv
// Row buffer and column counter: holds one latched row and presents its pixels
// oldest-first (highest element index first), flagging the final column.
module row_serializer import bus_pkg::*; #(
    parameter int bitWidth = BIT_WIDTH_DEF,
    parameter int im_size  = IM_SIZE_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        load,
    input  logic                        advance,
    input  logic [bitWidth*im_size-1:0] row_in,
    output logic [bitWidth-1:0]         pixel,
    output logic                        last_col
);

    localparam int COL_W = (im_size > 1) ? $clog2(im_size) : 1;
    localparam logic [COL_W-1:0] LAST = COL_W'(im_size - 1);

    logic [bitWidth*im_size-1:0] row_q;
    logic [COL_W-1:0]            col_q;
    logic [COL_W-1:0]            sel;

    // Column 0 maps to element im_size-1, undoing the reader's shift order.
    assign sel      = LAST - col_q;
    assign pixel    = row_q[sel*bitWidth +: bitWidth];
    assign last_col = (col_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clear) begin
            col_q <= '0;
        end else if (load) begin
            row_q <= row_in;
            col_q <= '0;
        end else if (advance) begin
            col_q <= last_col ? '0 : col_q + COL_W'(1);
        end
    end

endmodule

// File: rtl/row_writer.sv
// Serialises accepted image rows into single-pixel RAM writes with an auto-incrementing
// address and pulses frame_done one cycle after the last pixel of each frame.
module row_writer import bus_pkg::*; #(
    parameter int bitWidth   = BIT_WIDTH_DEF,
    parameter int im_size    = IM_SIZE_DEF,
    parameter int frame_rows = FRAME_ROWS_DEF,
    parameter int addr_width = 11,
    parameter int base_addr  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       frame_restart,
    row_writer_if.slave bus,
    output logic       busy,
    output logic       frame_done
);

    localparam int RC_W = $clog2(frame_rows + 1);
    localparam logic [addr_width-1:0] BASE     = addr_width'(base_addr);
    localparam logic [RC_W-1:0]       LAST_ROW = RC_W'(frame_rows - 1);

    rw_state_t             state_q, state_d;
    logic [addr_width-1:0] ptr_q, ptr_d;
    logic [RC_W-1:0]       row_cnt_q, row_cnt_d;
    logic                  we_q, we_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [bitWidth-1:0]   data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  row_ready;
    logic                  load;
    logic                  advance;
    logic [bitWidth-1:0]   pixel;
    logic                  last_col;

    row_serializer #(
        .bitWidth (bitWidth),
        .im_size  (im_size)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .clear    (frame_restart),
        .load     (load),
        .advance  (advance),
        .row_in   (bus.row_in),
        .pixel    (pixel),
        .last_col (last_col)
    );

    assign row_ready     = (state_q == IDLE) & en & ~frame_restart & ~rst;
    assign bus.row_ready = row_ready;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_data  = data_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= BASE;
            row_cnt_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= BASE;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            row_cnt_q <= row_cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        row_cnt_d = row_cnt_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;

        // Restart outranks every state action, including a pending DONE pulse.
        if (frame_restart) begin
            state_d   = IDLE;
            ptr_d     = BASE;
            row_cnt_d = '0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.row_valid && row_ready) begin
                        load    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (en) begin
                        advance = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        data_d  = pixel;
                        ptr_d   = ptr_q + addr_width'(1);
                        if (last_col) begin
                            row_cnt_d = row_cnt_q + RC_W'(1);
                            busy_d    = 1'b0;
                            state_d   = (row_cnt_q == LAST_ROW) ? DONE : IDLE;
                        end
                    end
                end
                DONE: begin
                    done_d    = 1'b1;
                    ptr_d     = BASE;
                    row_cnt_d = '0;
                    state_d   = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_writer.sv
// Bench for row_writer: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations on the captured write log.
module tb_row_writer;
    import bus_pkg::*;

    localparam int BW   = 16;
    localparam int IM   = 28;
    localparam int FR   = 28;
    localparam int AW   = 11;
    localparam int BASE = 0;

    logic clk = 1'b0;
    logic rst, en, frame_restart, busy, frame_done;

    always #5 clk = ~clk;

    row_writer_if #(.bitWidth(BW), .im_size(IM), .addr_width(AW)) bus ();

    row_writer #(
        .bitWidth   (BW),
        .im_size    (IM),
        .frame_rows (FR),
        .addr_width (AW),
        .base_addr  (BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .frame_restart (frame_restart),
        .bus           (bus),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW*IM-1:0] mk_row(input int seed);
        logic [BW*IM-1:0] r;
        r = '0;
        for (int k = 0; k < IM; k++) r[k*BW +: BW] = BW'(seed + k + 1);
        return r;
    endfunction

    function automatic int at_q(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Reference model: an accepted row becomes a queue of pixels in write order;
    // the address is derived from rows completed and pixels already written.
    int               m_phase = 0;  // 0 idle, 1 writing, 2 frame-end cycle
    int               pend[$];
    int               m_rows = 0;
    logic             e_we, e_busy, e_done;
    logic [AW-1:0]    e_addr;
    logic [BW-1:0]    e_data;
    logic             s_rst, s_en, s_fr, s_rv;
    logic [BW*IM-1:0] s_row;
    int               cyc = 0;

    int lg_addr[$];
    int lg_data[$];
    int lg_cyc[$];
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;

    always begin
        @(posedge clk);
        s_rst = rst; s_en = en; s_fr = frame_restart; s_rv = bus.row_valid; s_row = bus.row_in;
        e_we   = 1'b0;
        e_done = 1'b0;
        if (s_rst) begin
            m_phase = 0; pend.delete(); m_rows = 0;
            e_addr = AW'(BASE); e_data = '0; e_busy = 1'b0;
        end else if (s_fr) begin
            m_phase = 0; pend.delete(); m_rows = 0; e_busy = 1'b0;
        end else if (m_phase == 0) begin
            if (s_rv && s_en) begin
                for (int k = IM - 1; k >= 0; k--) pend.push_back(int'(s_row[k*BW +: BW]));
                m_phase = 1;
                e_busy  = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (s_en) begin
                e_we   = 1'b1;
                e_addr = AW'(BASE + m_rows * IM + (IM - pend.size()));
                e_data = BW'(pend.pop_front());
                if (pend.size() == 0) begin
                    m_rows++;
                    e_busy  = 1'b0;
                    m_phase = (m_rows == FR) ? 2 : 0;
                end
            end
        end else begin
            e_done  = 1'b1;
            m_rows  = 0;
            m_phase = 0;
        end
        #1;
        cyc++;
        chk("ram_we", 32'(bus.ram_we), 32'(e_we));
        chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
        chk("ram_data", 32'(bus.ram_data), 32'(e_data));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("row_ready", 32'(bus.row_ready),
            32'((m_phase == 0) && en && !frame_restart && !rst));
        if (bus.ram_we === 1'b1) begin
            lg_addr.push_back(int'(bus.ram_addr));
            lg_data.push_back(int'(bus.ram_data));
            lg_cyc.push_back(cyc);
        end
        if (busy === 1'b1) busy_cnt++;
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_log();
        lg_addr.delete(); lg_data.delete(); lg_cyc.delete();
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    endtask

    task automatic restart_pulse();
        frame_restart = 1'b1;
        @(negedge clk);
        frame_restart = 1'b0;
    endtask

    task automatic send_row(input int seed);
        bus.row_in    = mk_row(seed);
        bus.row_valid = 1'b1;
        @(negedge clk);
        bus.row_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int i;
        for (i = 0; i < budget && lg_addr.size() < n; i++) @(negedge clk);
        if (lg_addr.size() < n) chk(name, 32'(lg_addr.size()), 32'(n));
    endtask

    initial begin
        int errs;
        rst = 1'b1; en = 1'b1; frame_restart = 1'b0;
        bus.row_valid = 1'b0; bus.row_in = '0;

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_we", 32'(bus.ram_we), 0);
        chk("rst_addr", 32'(bus.ram_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_ready", 32'(bus.row_ready), 1);

        // Single row, element k = k+1
        @(negedge clk);
        clear_log();
        send_row(0);
        repeat (32) @(negedge clk);
        chk("row1_count", 32'(lg_addr.size()), 28);
        chk("row1_addr0", 32'(at_q(lg_addr, 0)), 0);
        chk("row1_data0", 32'(at_q(lg_data, 0)), 28);
        chk("row1_addr27", 32'(at_q(lg_addr, 27)), 27);
        chk("row1_data27", 32'(at_q(lg_data, 27)), 1);
        chk("row1_busy_cycles", 32'(busy_cnt), 28);
        restart_pulse();

        // Full frame, row_valid held with data changing every cycle
        clear_log();
        bus.row_valid = 1'b1;
        for (int i = 0; i < 1000 && lg_addr.size() < 785; i++) begin
            bus.row_in = mk_row(i * 37);
            @(negedge clk);
        end
        bus.row_valid = 1'b0;
        if (lg_addr.size() < 785) chk("frame_timeout", 32'(lg_addr.size()), 785);
        errs = 0;
        for (int i = 0; i < 784; i++) if (at_q(lg_addr, i) != i) errs++;
        chk("frame_addr_seq", 32'(errs), 0);
        chk("frame_data0", 32'(at_q(lg_data, 0)), 28);
        chk("frame_last_addr", 32'(at_q(lg_addr, 783)), 783);
        chk("frame_next_addr", 32'(at_q(lg_addr, 784)), 0);
        chk("frame_done_cnt", 32'(done_cnt), 1);
        chk("frame_done_cyc", 32'(done_cyc), 32'(at_q(lg_cyc, 783) + 1));
        chk("frame_row_gap", 32'(at_q(lg_cyc, 28) - at_q(lg_cyc, 27)), 2);
        chk("frame_end_gap", 32'(at_q(lg_cyc, 784) - at_q(lg_cyc, 783)), 3);
        repeat (32) @(negedge clk);
        restart_pulse();

        // en low for 3 cycles at column 10
        clear_log();
        send_row(100);
        wait_writes(10, 40, "pause_timeout");
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (30) @(negedge clk);
        chk("pause_count", 32'(lg_addr.size()), 28);
        chk("pause_addr10", 32'(at_q(lg_addr, 10)), 10);
        chk("pause_data10", 32'(at_q(lg_data, 10)), 118);
        chk("pause_gap", 32'(at_q(lg_cyc, 10) - at_q(lg_cyc, 9)), 4);
        restart_pulse();

        // frame_restart at column 5 of row 3 with row_valid still high
        clear_log();
        bus.row_valid = 1'b1;
        for (int i = 0; i < 200 && lg_addr.size() < 89; i++) begin
            bus.row_in = mk_row(i);
            @(negedge clk);
        end
        if (lg_addr.size() < 89) chk("restart_timeout", 32'(lg_addr.size()), 89);
        restart_pulse();
        bus.row_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("restart_no_write", 32'(lg_addr.size()), 89);
        chk("restart_idle_busy", 32'(busy), 0);
        send_row(500);
        repeat (32) @(negedge clk);
        chk("restart_count", 32'(lg_addr.size()), 117);
        chk("restart_addr0", 32'(at_q(lg_addr, 89)), 0);
        chk("restart_data0", 32'(at_q(lg_data, 89)), 528);
        chk("restart_addr27", 32'(at_q(lg_addr, 116)), 27);
        chk("restart_no_done", 32'(done_cnt), 0);

        // rst in the middle of a row
        clear_log();
        send_row(7);
        wait_writes(6, 40, "rst_mid_timeout");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_count", 32'(lg_addr.size()), 6);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_addr", 32'(bus.ram_addr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
